// File: rtl/controller_poller_m.sv
// Two-controller serial poller: latches both pads, clocks out eight bits each,
// and commits the decoded (1 = pressed) button bytes atomically for CPU reads.
module controller_poller_m #(
  parameter int HALF_PERIOD = 76
) (
  input  logic       clk_12_5875,
  input  logic       rst_B,
  input  logic       start,
  input  logic       SELECT_controller,
  input  logic       cpu_address_lo,
  output logic [7:0] data_out,
  input  logic [1:0] ctrl_data_B,
  output logic       ctrl_latch,
  output logic       ctrl_clk,
  output logic       busy,
  output logic       done
);

  localparam int CW = $clog2(16 * HALF_PERIOD + 2);
  localparam logic [CW-1:0] LATCH_RELOAD = CW'(2 * HALF_PERIOD - 1);
  localparam logic [CW-1:0] HALF_RELOAD  = CW'(HALF_PERIOD - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LATCH    = 3'd1,
    CLK_HIGH = 3'd2,
    CLK_LOW  = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic          latch_q;
  logic          clk_q;
  logic          busy_q;
  logic          done_q;
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [7:0]    sh_q  [2];
  logic [7:0]    sh_d  [2];
  logic [7:0]    res_q [2];

  // Pads drive active-low data; store inverted so a set bit means pressed.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_shift
      assign sh_d[gi] = {sh_q[gi][6:0], ~sync2_q[gi]};
    end
  endgenerate

  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= ctrl_data_B;
      sync2_q <= sync1_q;
    end
  end

  always_ff @(posedge clk_12_5875 or negedge rst_B) begin
    if (!rst_B) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= 3'd0;
      latch_q  <= 1'b0;
      clk_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      sh_q[0]  <= 8'h00;
      sh_q[1]  <= 8'h00;
      res_q[0] <= 8'h00;
      res_q[1] <= 8'h00;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= LATCH;
            latch_q <= 1'b1;
            busy_q  <= 1'b1;
            cnt_q   <= LATCH_RELOAD;
          end
        end
        LATCH: begin
          if (cnt_q == '0) begin
            sh_q[0] <= sh_d[0];
            sh_q[1] <= sh_d[1];
            state_q <= CLK_HIGH;
            latch_q <= 1'b0;
            clk_q   <= 1'b1;
            cnt_q   <= HALF_RELOAD;
            bit_q   <= 3'd1;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        CLK_HIGH: begin
          if (cnt_q == '0) begin
            state_q <= CLK_LOW;
            clk_q   <= 1'b0;
            cnt_q   <= HALF_RELOAD;
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        CLK_LOW: begin
          if (cnt_q == '0) begin
            sh_q[0] <= sh_d[0];
            sh_q[1] <= sh_d[1];
            if (bit_q == 3'd7) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= CLK_HIGH;
              clk_q   <= 1'b1;
              cnt_q   <= HALF_RELOAD;
              bit_q   <= bit_q + 3'd1;
            end
          end else begin
            cnt_q <= cnt_q - CW'(1);
          end
        end
        DONE: begin
          // Both bytes commit on the same edge so a CPU never sees a mix.
          res_q[0] <= sh_q[0];
          res_q[1] <= sh_q[1];
          busy_q   <= 1'b0;
          state_q  <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          latch_q <= 1'b0;
          clk_q   <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    data_out = 8'h00;
    if (SELECT_controller) begin
      data_out = cpu_address_lo ? res_q[1] : res_q[0];
    end
  end

  assign ctrl_latch = latch_q;
  assign ctrl_clk   = clk_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_controller_poller_m.sv
// Bench for controller_poller_m: pad models, per-cycle timing checks and a
// scoreboard of expected committed button bytes.
module tb_controller_poller_m;

  localparam int H = 4;
  localparam int N = 16 * H + 1;

  logic       clk = 1'b0;
  logic       rst_B = 1'b0;
  logic       start = 1'b0;
  logic       sel = 1'b0;
  logic       addr = 1'b0;
  logic [7:0] data_out;
  logic [1:0] ctrl_data_B;
  logic       ctrl_latch;
  logic       ctrl_clk;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  logic [7:0]  pat0_cur = 8'hFF;
  logic [7:0]  pat1_cur = 8'hFF;
  logic [3:0]  idx = 4'd8;
  logic        clk_d = 1'b0;
  logic [7:0]  committed0 = 8'h00;
  logic [7:0]  committed1 = 8'h00;
  logic [15:0] sb_q[$];

  controller_poller_m #(.HALF_PERIOD(H)) dut (
    .clk_12_5875      (clk),
    .rst_B            (rst_B),
    .start            (start),
    .SELECT_controller(sel),
    .cpu_address_lo   (addr),
    .data_out         (data_out),
    .ctrl_data_B      (ctrl_data_B),
    .ctrl_latch       (ctrl_latch),
    .ctrl_clk         (ctrl_clk),
    .busy             (busy),
    .done             (done)
  );

  always #5 clk = ~clk;

  function automatic logic bit_of(input logic [7:0] pat, input logic [3:0] i);
    return (i < 4'd8) ? pat[i[2:0]] : 1'b1;
  endfunction

  // Pad model: latch loads button A, each ctrl_clk rising edge advances one button.
  always @(posedge clk) begin
    clk_d <= ctrl_clk;
    if (ctrl_latch) idx <= 4'd0;
    else if (ctrl_clk && !clk_d) idx <= idx + 4'd1;
  end
  assign ctrl_data_B = {bit_of(pat1_cur, idx), bit_of(pat0_cur, idx)};

  function automatic logic [7:0] exp_of(input logic [7:0] pat);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[7-i] = ~pat[i];
    return r;
  endfunction

  function automatic logic exp_clk(input int c);
    for (int i = 1; i <= 7; i++)
      if (c >= 2*H*i + 1 && c <= 2*H*i + H) return 1'b1;
    return 1'b0;
  endfunction

  always @(negedge clk) begin
    if (rst_B === 1'b1) begin
      checks++;
      if (ctrl_latch && ctrl_clk) begin
        errors++;
        $display("FAIL latch_clk_overlap: latch=%b clk=%b, required not both high", ctrl_latch, ctrl_clk);
      end
      checks++;
      if (busy !== (dut.state_q != 3'd0)) begin
        errors++;
        $display("FAIL busy_vs_state: busy=%b state=%0d", busy, dut.state_q);
      end
    end
  end

  task automatic run_poll(input logic [7:0] p0, input logic [7:0] p1,
                          input bit hold, input bit already, input string name);
    logic [15:0] exp;
    pat0_cur = p0;
    pat1_cur = p1;
    sb_q.push_back({exp_of(p1), exp_of(p0)});
    sel  = 1'b1;
    addr = 1'b0;
    if (!already) begin
      @(negedge clk);
      start = 1'b1;
    end
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge clk);
      if (c == 1) start = hold;
      checks++;
      if (busy !== (c <= N)) begin
        errors++;
        $display("FAIL %s busy c=%0d: got %b expected %b", name, c, busy, (c <= N));
      end
      checks++;
      if (ctrl_latch !== (c >= 1 && c <= 2*H)) begin
        errors++;
        $display("FAIL %s latch c=%0d: got %b expected %b", name, c, ctrl_latch, (c <= 2*H));
      end
      checks++;
      if (ctrl_clk !== exp_clk(c)) begin
        errors++;
        $display("FAIL %s ctrl_clk c=%0d: got %b expected %b", name, c, ctrl_clk, exp_clk(c));
      end
      checks++;
      if (done !== (c == N)) begin
        errors++;
        $display("FAIL %s done c=%0d: got %b expected %b", name, c, done, (c == N));
      end
      if (c <= N) begin
        checks++;
        if (data_out !== committed0) begin
          errors++;
          $display("FAIL %s read_old c=%0d: got %h expected %h", name, c, data_out, committed0);
        end
      end else begin
        checks++;
        if (sb_q.size() == 0) begin
          errors++;
          $display("FAIL %s scoreboard: empty, expected one entry", name);
          exp = 16'h0000;
        end else begin
          exp = sb_q.pop_front();
        end
        checks++;
        if (data_out !== exp[7:0]) begin
          errors++;
          $display("FAIL %s reg0: got %h expected %h", name, data_out, exp[7:0]);
        end
        addr = 1'b1;
        #1;
        checks++;
        if (data_out !== exp[15:8]) begin
          errors++;
          $display("FAIL %s reg1: got %h expected %h", name, data_out, exp[15:8]);
        end
        addr = 1'b0;
        committed0 = exp[7:0];
        committed1 = exp[15:8];
        $display("poll %s: pads %h/%h -> reg0=%h reg1=%h", name, p0, p1, exp[7:0], exp[15:8]);
      end
    end
  endtask

  task automatic test_reset();
    sel = 1'b1;
    addr = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({ctrl_latch, ctrl_clk, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected 0000", {ctrl_latch, ctrl_clk, busy, done});
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_reg0: got %h expected 00", data_out);
    end
    addr = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL reset_reg1: got %h expected 00", data_out);
    end
    addr = 1'b0;
    @(negedge clk);
    rst_B = 1'b1;
    $display("reset: outputs idle, registers 00");
  endtask

  task automatic test_single_poll();
    // A..Right = 1,0,1,1,1,1,1,0 active-low on controller 0 -> 8'h41
    run_poll(8'h7D, 8'hFE, 1'b0, 1'b0, "single");
    checks++;
    if (committed0 !== 8'h41) begin
      errors++;
      $display("FAIL single_value: got %h expected 41", committed0);
    end
  endtask

  task automatic test_select();
    run_poll(8'h00, 8'hFF, 1'b0, 1'b0, "split");
    sel = 1'b0;
    for (int a = 0; a < 2; a++) begin
      addr = a[0];
      #1;
      checks++;
      if (data_out !== 8'h00) begin
        errors++;
        $display("FAIL deselect addr=%0d: got %h expected 00", a, data_out);
      end
    end
    sel = 1'b1;
    addr = 1'b0;
    $display("select: deselected reads return 00");
  endtask

  task automatic test_back_to_back();
    run_poll(8'hA5, 8'h3C, 1'b1, 1'b0, "b2b_first");
    run_poll(8'h5A, 8'hC3, 1'b0, 1'b1, "b2b_second");
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_poll();
    pat0_cur = 8'h0F;
    pat1_cur = 8'hF0;
    sel = 1'b1;
    addr = 1'b0;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    rst_B = 1'b0;
    #1;
    checks++;
    if ({ctrl_latch, ctrl_clk, busy, done} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_outputs: got %b expected 0000", {ctrl_latch, ctrl_clk, busy, done});
    end
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL midreset_reg0: got %h expected 00", data_out);
    end
    addr = 1'b1;
    #1;
    checks++;
    if (data_out !== 8'h00) begin
      errors++;
      $display("FAIL midreset_reg1: got %h expected 00", data_out);
    end
    addr = 1'b0;
    committed0 = 8'h00;
    committed1 = 8'h00;
    repeat (3) @(negedge clk);
    rst_B = 1'b1;
    for (int c = 0; c < N + 10; c++) begin
      @(negedge clk);
      checks++;
      if (done !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00) begin
        errors++;
        $display("FAIL midreset_quiet c=%0d: done=%b busy=%b data=%h expected 0/0/00", c, done, busy, data_out);
      end
    end
    $display("reset mid-poll: aborted with no commit");
    run_poll(8'h0F, 8'hF0, 1'b0, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int k = 0; k < 3; k++)
      run_poll(8'($urandom), 8'($urandom), 1'b0, 1'b0, "random");
  endtask

  initial begin
    test_reset();
    test_single_poll();
    test_select();
    test_back_to_back();
    run_poll(8'hFF, 8'h00, 1'b0, 1'b0, "read_change");
    test_reset_mid_poll();
    test_random();
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left: %0d entries, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
